// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default frame geometry.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam int unsigned DEF_DATABITS   = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd pin; reset value is a parameter
// so the line reads as idle (high) straight out of reset.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/[parity]/stop deframing into a one-entry holding
// register with valid/rd handshake. Parity stage compiled in with UART_RX_PARITY_EN.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATABITS   = DEF_DATABITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baudrate,
    input  logic                rxd,
    input  logic                rd,
    output logic [DATABITS-1:0] data,
    output logic                valid,
    output logic                ferr,
    output logic                perr,
    output logic                overrun,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATABITS + 1);

    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATABITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    rx_state_t             r_state;
    rx_state_t             w_state_next;
    logic [CNT_W-1:0]      r_tick_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATABITS-1:0]   r_shift;
    logic [DATABITS-1:0]   r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_perr;
    logic                  r_overrun;
    logic                  r_armed;

    logic                  w_rxd;
    logic                  w_half_done;
    logic                  w_bit_done;
    logic                  w_last_bit;
    logic                  w_sample_data;
    logic                  w_complete;
    logic                  w_par_err;
`ifdef UART_RX_PARITY_EN
    logic                  w_sample_par;
    logic                  r_par_err;
`endif

    rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (rxd),
        .o_q   (w_rxd)
    );

    assign w_half_done = (r_tick_cnt == HALF_TICK);
    assign w_bit_done  = (r_tick_cnt == LAST_TICK);
    assign w_last_bit  = (r_bit_idx == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (baudrate) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxd && r_armed) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_half_done) begin
                    w_state_next = w_rxd ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state != ST_IDLE);
        w_sample_data = 1'b0;
        w_complete    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_sample_par  = 1'b0;
`endif
        if (baudrate && w_bit_done) begin
            case (r_state)
                ST_DATA:   w_sample_data = 1'b1;
`ifdef UART_RX_PARITY_EN
                ST_PARITY: w_sample_par  = 1'b1;
`endif
                ST_STOP:   w_complete    = 1'b1;
                default:   ;
            endcase
        end
    end

    // Tick counter restarts at every sample point so later samples stay mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (baudrate) begin
            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_idx  <= '0;
                end
                ST_START: begin
                    r_tick_cnt <= w_half_done ? '0 : r_tick_cnt + 1'b1;
                end
                ST_DATA: begin
                    r_tick_cnt <= w_bit_done ? '0 : r_tick_cnt + 1'b1;
                    if (w_bit_done) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                default: begin
                    r_tick_cnt <= w_bit_done ? '0 : r_tick_cnt + 1'b1;
                end
            endcase
        end
    end

    // A low stop bit (break) disarms start detection until the line returns high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b1;
        end else if (w_complete && !w_rxd) begin
            r_armed <= 1'b0;
        end else if (baudrate && w_rxd) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_sample_data) begin
            r_shift <= {w_rxd, r_shift[DATABITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_sample_par) begin
            r_par_err <= w_rxd ^ (^r_shift) ^ PAR_ODD;
        end
    end

    assign w_par_err = r_par_err;
`else
    // PARITY_ODD has no effect without the parity stage.
    assign w_par_err = PAR_ODD & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete) begin
                r_data <= r_shift;
                r_ferr <= ~w_rxd;
                r_perr <= w_par_err;
            end
            r_valid <= w_complete | (r_valid & ~rd);
            if (w_complete && r_valid && !rd) begin
                r_overrun <= 1'b1;
            end else if (rd && r_valid) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign ferr    = r_ferr;
    assign perr    = r_perr;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of whole frames plus hand sequences for glitch,
// break, mid-frame reset; parity cases become active when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int unsigned DB       = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          baudrate = 1'b0;
    logic          rxd      = 1'b1;
    logic          rd       = 1'b0;
    logic [DB-1:0] data;
    logic          valid;
    logic          ferr;
    logic          perr;
    logic          overrun;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par_ok;
        logic       do_rd;
        logic [7:0] e_data;
        logic       e_ferr;
        logic       e_ovr;
    } vec_t;

    uart_rx #(
        .DATABITS   (DB),
        .OVERSAMPLE (OS),
        .PARITY_ODD (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baudrate (baudrate),
        .rxd      (rxd),
        .rd       (rd),
        .data     (data),
        .valid    (valid),
        .ferr     (ferr),
        .perr     (perr),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 baudrate = 1'b1;
            @(posedge clk);
            #1 baudrate = 1'b0;
        end
    end

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_data, input logic e_valid,
                             input logic e_ferr, input logic e_perr, input logic e_ovr,
                             input logic e_busy);
        chk({tag, ".data"},    data,    e_data);
        chk({tag, ".valid"},   8'(valid),   8'(e_valid));
        chk({tag, ".ferr"},    8'(ferr),    8'(e_ferr));
        chk({tag, ".perr"},    8'(perr),    8'(e_perr));
        chk({tag, ".overrun"}, 8'(overrun), 8'(e_ovr));
        chk({tag, ".busy"},    8'(busy),    8'(e_busy));
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) begin
            send_bit(d[i]);
        end
        if (PAR_EN) begin
            send_bit((^d) ^ ~par_ok);
        end
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        wait_clk(1);
        rd = 1'b0;
    endtask

    initial begin : main
        vec_t vecs [9];
        logic [7:0] partial;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0};
        vecs[3] = '{8'h34, 1'b1, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};

        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].d, vecs[i].par_ok, vecs[i].stop);
            check_out($sformatf("vec%0d", i), vecs[i].e_data, 1'b1, vecs[i].e_ferr,
                      PAR_EN & ~vecs[i].par_ok, vecs[i].e_ovr, 1'b0);
            if (vecs[i].do_rd) begin
                pulse_rd();
                chk($sformatf("vec%0d.rd_valid", i), 8'(valid), 8'h00);
                chk($sformatf("vec%0d.rd_overrun", i), 8'(overrun), 8'h00);
            end
        end

        // Start glitch of 4 ticks must be rejected at the half-bit re-sample.
        rxd = 1'b0;
        wait_clk(12);
        chk("glitch.busy_high", 8'(busy), 8'h01);
        wait_clk(TICK_DIV * 4 - 12);
        rxd = 1'b1;
        wait_clk(48);
        chk("glitch.busy_low", 8'(busy), 8'h00);
        chk("glitch.no_valid", 8'(valid), 8'h00);
        pulse_rd();
        chk("idle_rd.valid", 8'(valid), 8'h00);
        chk("idle_rd.overrun", 8'(overrun), 8'h00);
        send_frame(8'h3C, 1'b1, 1'b1);
        check_out("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_rd();

        // Break: line held low well past one frame.
        rxd = 1'b0;
        wait_clk(BIT_CLKS * 12);
        check_out("break", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_rd();
        wait_clk(BIT_CLKS * 2);
        chk("break_hold.busy", 8'(busy), 8'h00);
        chk("break_hold.valid", 8'(valid), 8'h00);
        rxd = 1'b1;
        wait_clk(BIT_CLKS * 2);
        send_frame(8'h5A, 1'b1, 1'b1);
        check_out("after_break", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Second frame without rd, then reset partway through a third.
        send_frame(8'hE1, 1'b1, 1'b1);
        check_out("pre_reset", 8'hE1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        partial = 8'hC9;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(partial[i]);
        end
        chk("midframe.busy", 8'(busy), 8'h01);
        rxd = 1'b1;
        rst = 1'b1;
        wait_clk(1);
        check_out("midframe_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_clk(BIT_CLKS * 2);
        check_out("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC9, 1'b1, 1'b1);
        check_out("after_rst", 8'hC9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
